// File: rtl/alu_op_sequencer_pkg.sv
// Shared ALU definitions: control codes, op classes and the sequencer state encoding.
// Used by both the ALU datapath and the ALU op sequencer.
package alu_op_sequencer_pkg;

    localparam int ALU_CTRL_W = 5;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 5'b00000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 5'b00001;
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL = 5'b00010;
    localparam logic [ALU_CTRL_W-1:0] ALU_DIV = 5'b00011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SHR = 5'b00100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SHL = 5'b00101;
    localparam logic [ALU_CTRL_W-1:0] ALU_ROR = 5'b00110;
    localparam logic [ALU_CTRL_W-1:0] ALU_ROL = 5'b00111;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 5'b01000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 5'b01001;
    localparam logic [ALU_CTRL_W-1:0] ALU_NEG = 5'b01010;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOT = 5'b01011;

    typedef enum logic [1:0] {
        CLS_TWO,
        CLS_ONE,
        CLS_WIDE,
        CLS_ILLEGAL
    } op_class_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_Y,
        ST_EXEC,
        ST_WB_LO,
        ST_WB_HI
    } seq_state_e;

    function automatic op_class_e classify(input logic [ALU_CTRL_W-1:0] op);
        op_class_e cls;
        cls = CLS_ILLEGAL;
        if (op == ALU_MUL || op == ALU_DIV)
            cls = CLS_WIDE;
        else if (op inside {ALU_SHR, ALU_SHL, ALU_ROR, ALU_ROL, ALU_NEG, ALU_NOT})
            cls = CLS_ONE;
        else if (op inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR})
            cls = CLS_TWO;
        return cls;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_class.sv
// Combinational op_code decode into the flags the sequencer needs.
module alu_op_class
    import alu_op_sequencer_pkg::*;
(
    input  logic [ALU_CTRL_W-1:0] op_code,
    output logic                  legal,
    output logic                  wide,
    output logic                  unary
);

    op_class_e cls;

    always_comb begin
        cls   = classify(op_code);
        legal = (cls != CLS_ILLEGAL);
        wide  = (cls == CLS_WIDE);
        unary = (cls == CLS_ONE);
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences datapath strobes for one ALU instruction at a time, stretching EXEC
// for multi-cycle MUL/DIV and writing wide results back through LO then HI.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  op_valid,
    input  logic [ALU_CTRL_W-1:0] op_code,
    output logic                  op_ready,
    output logic                  ra_out,
    output logic                  y_in,
    output logic                  rb_out,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  z_in,
    output logic                  zlo_out,
    output logic                  zhi_out,
    output logic                  rc_in,
    output logic                  lo_in,
    output logic                  hi_in,
    output logic                  done,
    output logic                  op_err
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

    seq_state_e            state, state_nxt;
    logic [ALU_CTRL_W-1:0] op_q;
    logic [ALU_CTRL_W-1:0] ctrl_q;
    logic                  wide_q;
    logic                  unary_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  err_q;
    logic                  cls_legal;
    logic                  cls_wide;
    logic                  cls_unary;
    logic                  accept;

    alu_op_class u_class (
        .op_code (op_code),
        .legal   (cls_legal),
        .wide    (cls_wide),
        .unary   (cls_unary)
    );

    // Ready depends on state alone so the handshake never loops through next-state logic.
    assign op_ready = (state == ST_IDLE);
    assign accept   = op_valid & op_ready;
    assign alu_ctrl = ctrl_q;
    assign op_err   = err_q;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state   <= ST_IDLE;
            op_q    <= ALU_ADD;
            ctrl_q  <= ALU_ADD;
            wide_q  <= 1'b0;
            unary_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= accept & ~cls_legal;
            if (accept && cls_legal) begin
                op_q    <= op_code;
                wide_q  <= cls_wide;
                unary_q <= cls_unary;
            end
            // ctrl updates on entry to EXEC and then holds until the next instruction's EXEC.
            if (state == ST_LOAD_Y) begin
                ctrl_q <= op_q;
                if (!wide_q)
                    cnt_q <= '0;
                else if (op_q == ALU_MUL)
                    cnt_q <= MUL_LD;
                else
                    cnt_q <= DIV_LD;
            end else if (state == ST_EXEC && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ra_out    = 1'b0;
        y_in      = 1'b0;
        rb_out    = 1'b0;
        z_in      = 1'b0;
        zlo_out   = 1'b0;
        zhi_out   = 1'b0;
        rc_in     = 1'b0;
        lo_in     = 1'b0;
        hi_in     = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                // Illegal codes are swallowed here; op_err is raised from err_q next cycle.
                if (accept && cls_legal)
                    state_nxt = ST_LOAD_Y;
            end
            ST_LOAD_Y: begin
                ra_out    = 1'b1;
                y_in      = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                rb_out = ~unary_q;
                if (cnt_q == '0) begin
                    z_in      = 1'b1;
                    state_nxt = ST_WB_LO;
                end
            end
            ST_WB_LO: begin
                zlo_out = 1'b1;
                if (wide_q) begin
                    lo_in     = 1'b1;
                    state_nxt = ST_WB_HI;
                end else begin
                    rc_in     = 1'b1;
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WB_HI: begin
                zhi_out   = 1'b1;
                hi_in     = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
